// File: rtl/tdm_demux_4.sv
// 4-channel TDM demultiplexer: tracks the slot sequence from the 4:1 mux, presents a frame in parallel.
// Optional build macro TDM_DEMUX_ERRCNT_EN adds a saturating 8-bit framing-error counter (err_cnt).
module tdm_demux_4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             frame,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic             out_valid,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       sel_r, sel_s;
    logic [WIDTH-1:0] shadow_r [3];
    logic [WIDTH-1:0] shadow_s [3];
    logic [WIDTH-1:0] out_r [4];
    logic [WIDTH-1:0] out_s [4];
    logic             out_valid_r, out_valid_s;
    logic             sync_err_r, sync_err_s;
    logic             locked_r;

    // Next-state, slot capture and framing-violation decode.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        shadow_s    = shadow_r;
        out_s       = out_r;
        out_valid_s = 1'b0;
        sync_err_s  = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (in_valid && frame) begin
                    shadow_s[0] = in_data;
                    sel_s       = 2'd1;
                    state_s     = ST_LOCKED;
                end else begin
                    sel_s = 2'd0;
                end
            end
            ST_LOCKED: begin
                if (!in_valid) begin
                    state_s = ST_LOCKED;
                end else if (frame) begin
                    // A marker anywhere but slot 0 restarts the frame with this sample.
                    sync_err_s  = (sel_r != 2'd0);
                    shadow_s[0] = in_data;
                    sel_s       = 2'd1;
                end else begin
                    case (sel_r)
                        2'd0: begin
                            sync_err_s = 1'b1;
                            state_s    = ST_HUNT;
                            sel_s      = 2'd0;
                        end
                        2'd1: begin
                            shadow_s[1] = in_data;
                            sel_s       = 2'd2;
                        end
                        2'd2: begin
                            shadow_s[2] = in_data;
                            sel_s       = 2'd3;
                        end
                        2'd3: begin
                            out_s[0]    = shadow_r[0];
                            out_s[1]    = shadow_r[1];
                            out_s[2]    = shadow_r[2];
                            out_s[3]    = in_data;
                            out_valid_s = 1'b1;
                            sel_s       = 2'd0;
                        end
                        default: begin
                            state_s = ST_HUNT;
                            sel_s   = 2'd0;
                        end
                    endcase
                end
            end
            default: begin
                state_s = ST_HUNT;
                sel_s   = 2'd0;
            end
        endcase
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HUNT;
            sel_r       <= 2'd0;
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            locked_r    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                shadow_r[i] <= {WIDTH{1'b0}};
            end
            for (int i = 0; i < 4; i++) begin
                out_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            out_valid_r <= out_valid_s;
            sync_err_r  <= sync_err_s;
            locked_r    <= (state_s == ST_LOCKED);
            shadow_r    <= shadow_s;
            out_r       <= out_s;
        end
    end

    assign out1      = out_r[0];
    assign out2      = out_r[1];
    assign out3      = out_r[2];
    assign out4      = out_r[3];
    assign out_valid = out_valid_r;
    assign sync_err  = sync_err_r;
    assign sel       = sel_r;
    assign locked    = locked_r;

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of framing violations.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (sync_err_s && (err_cnt_r != 8'd255)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    // Error counter not present in this build.
`endif

endmodule

// File: tb/tb_tdm_demux_4.sv
// Self-checking bench for tdm_demux_4: queue-based frame model checked every cycle plus directed literals.
module tb_tdm_demux_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         frame = 1'b0;
    logic [W-1:0] out1, out2, out3, out4;
    logic         out_valid, locked, sync_err;
    logic [1:0]   sel;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]   err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    tdm_demux_4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .frame(frame),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out_valid(out_valid), .sel(sel), .locked(locked), .sync_err(sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the partial frame is a queue; its length is the slot to fill next.
    logic [W-1:0] part[$];
    logic         m_locked = 1'b0;
    logic [W-1:0] m_out[4] = '{default: '0};
    logic         m_ov = 1'b0;
    logic         m_se = 1'b0;
    int           m_cnt = 0;

    always @(posedge clk) begin
        m_ov = 1'b0;
        m_se = 1'b0;
        if (rst) begin
            part.delete();
            m_locked = 1'b0;
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else if (in_valid) begin
            if (!m_locked) begin
                if (frame) begin
                    part.delete();
                    part.push_back(in_data);
                    m_locked = 1'b1;
                end
            end else if (frame) begin
                if (part.size() != 0) m_se = 1'b1;
                part.delete();
                part.push_back(in_data);
            end else if (part.size() == 0) begin
                m_se = 1'b1;
                m_locked = 1'b0;
            end else begin
                part.push_back(in_data);
                if (part.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = part[i];
                    m_ov = 1'b1;
                    part.delete();
                end
            end
            if (m_se && m_cnt < 255) m_cnt++;
        end
        #1;
        chk("out1", 32'(out1), 32'(m_out[0]));
        chk("out2", 32'(out2), 32'(m_out[1]));
        chk("out3", 32'(out3), 32'(m_out[2]));
        chk("out4", 32'(out4), 32'(m_out[3]));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("sync_err", 32'(sync_err), 32'(m_se));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("sel", 32'(sel), (m_locked ? 32'(part.size()) : 32'd0));
        chk("ov_se_excl", 32'(out_valid & sync_err), 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
    end

    // One clock of stimulus, applied on the falling edge.
    task automatic cyc(input logic v, input logic f, input logic [W-1:0] d);
        in_valid = v;
        frame = f;
        in_data = d;
        @(negedge clk);
    endtask

    task automatic chk_outs(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] e);
        chk({name, "_o1"}, 32'(out1), 32'(a));
        chk({name, "_o2"}, 32'(out2), 32'(b));
        chk({name, "_o3"}, 32'(out3), 32'(c));
        chk({name, "_o4"}, 32'(out4), 32'(e));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        cyc(1'b1, 1'b1, 4'h5);
        rst = 1'b0;
        chk_outs("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);

        // Clean frame 1,0,1,1
        cyc(1'b1, 1'b1, 4'h1);
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h1);
        chk("clean_no_ov", 32'(out_valid), 32'd0);
        cyc(1'b1, 1'b0, 4'h1);
        chk_outs("clean", 4'h1, 4'h0, 4'h1, 4'h1);
        chk("clean_ov", 32'(out_valid), 32'd1);
        chk("clean_sel", 32'(sel), 32'd0);
        chk("clean_locked", 32'(locked), 32'd1);
        cyc(1'b0, 1'b0, 4'h0);
        chk("clean_ov_pulse", 32'(out_valid), 32'd0);

        // Gapped frame A,5,3,C with two idle cycles between samples
        cyc(1'b1, 1'b1, 4'hA); cyc(1'b0, 1'b0, 4'hF); cyc(1'b0, 1'b1, 4'hF);
        cyc(1'b1, 1'b0, 4'h5); cyc(1'b0, 1'b0, 4'hF); cyc(1'b0, 1'b0, 4'hF);
        cyc(1'b1, 1'b0, 4'h3); cyc(1'b0, 1'b0, 4'hF);
        chk_outs("gap_hold", 4'h1, 4'h0, 4'h1, 4'h1);
        cyc(1'b0, 1'b0, 4'hF);
        cyc(1'b1, 1'b0, 4'hC);
        chk_outs("gapped", 4'hA, 4'h5, 4'h3, 4'hC);
        chk("gapped_ov", 32'(out_valid), 32'd1);

        // HUNT filtering
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 4'(i + 7));
            chk("hunt_no_err", 32'(sync_err), 32'd0);
            chk("hunt_no_ov", 32'(out_valid), 32'd0);
        end
        cyc(1'b1, 1'b1, 4'h2); cyc(1'b1, 1'b0, 4'h4); cyc(1'b1, 1'b0, 4'h6); cyc(1'b1, 1'b0, 4'h8);
        chk_outs("hunt", 4'h2, 4'h4, 4'h6, 4'h8);

        // Early frame
        cyc(1'b1, 1'b1, 4'h1); cyc(1'b1, 1'b0, 4'h2);
        cyc(1'b1, 1'b1, 4'h7);
        chk("early_err", 32'(sync_err), 32'd1);
        chk_outs("early_keep", 4'h2, 4'h4, 4'h6, 4'h8);
        cyc(1'b1, 1'b0, 4'h8); cyc(1'b1, 1'b0, 4'h9); cyc(1'b1, 1'b0, 4'hA);
        chk_outs("early", 4'h7, 4'h8, 4'h9, 4'hA);

        // Missing frame, then relock
        do_reset();
        cyc(1'b1, 1'b1, 4'h1); cyc(1'b1, 1'b0, 4'h2); cyc(1'b1, 1'b0, 4'h3); cyc(1'b1, 1'b0, 4'h4);
        cyc(1'b1, 1'b0, 4'hE);
        chk("miss_err", 32'(sync_err), 32'd1);
        chk("miss_locked", 32'(locked), 32'd0);
        chk("miss_sel", 32'(sel), 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
        chk("miss_cnt", 32'(err_cnt), 32'd1);
`endif
        cyc(1'b1, 1'b1, 4'hB); cyc(1'b1, 1'b0, 4'hC); cyc(1'b1, 1'b0, 4'hD); cyc(1'b1, 1'b0, 4'hE);
        chk_outs("relock", 4'hB, 4'hC, 4'hD, 4'hE);
        chk("relock_locked", 32'(locked), 32'd1);

        // Mid-frame reset with a coincident valid sample
        cyc(1'b1, 1'b1, 4'h3); cyc(1'b1, 1'b0, 4'h5);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 4'h9);
        rst = 1'b0;
        chk_outs("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        cyc(1'b1, 1'b0, 4'h6);
        cyc(1'b1, 1'b0, 4'h7);
        chk("mid_rst_no_ov", 32'(out_valid), 32'd0);

`ifdef TDM_DEMUX_ERRCNT_EN
        // Saturation: one lock plus 300 early frames
        do_reset();
        for (int i = 0; i < 301; i++) cyc(1'b1, 1'b1, 4'(i));
        chk("cnt_sat", 32'(err_cnt), 32'd255);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), 4'($urandom));
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4.md
Name: tdm_demux_4

Overview:
- 4-channel time-division demultiplexer; the receiving end of the team's 4:1 mux path.
- A 4:1 mux serialises i1..i4 onto one line, one slot per sample, with a frame marker on slot 0.
- This block tracks the slot sequence, captures each sample, and presents all four channels in parallel with a frame-complete strobe.
- Sits downstream of the mux stage and feeds channel consumers.

Parameters:
- WIDTH, 1, bit width of each sample and of each channel output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  serialised sample for the current slot.
- in_valid  input  1  in_data holds a sample this cycle.
- frame  input  1  qualifies a valid sample as slot 0; ignored when in_valid=0.
- out1  output  WIDTH  channel 1 (slot 0) value, registered.
- out2  output  WIDTH  channel 2 (slot 1) value, registered.
- out3  output  WIDTH  channel 3 (slot 2) value, registered.
- out4  output  WIDTH  channel 4 (slot 3) value, registered.
- out_valid  output  1  one-cycle pulse: out1..out4 just updated with a complete frame.
- sel  output  2  slot index the next valid sample will fill (s1 = sel[1], s2 = sel[0] in mux terms).
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset: while rst=1 at an edge, the following values apply: out1..out4=0, out_valid=0, sync_err=0, sel=0, locked=0, state=HUNT, shadow registers=0. Reset overrides all inputs and discards any partial frame.
- States:
  - HUNT: ignore in_valid with frame=0, no error. On in_valid&frame, store the sample in shadow[0], set sel=1, and go to LOCKED.
  - LOCKED: on each in_valid, store in_data into shadow[sel]; sel increments mod 4. in_valid=0 holds all state; gaps of any length are allowed.
- Frame completion: the sample captured with sel=3 is written directly to out4 on the same edge. On that edge, shadow[0..2] go to out1..out3, out_valid=1 for exactly one cycle, and sel wraps to 0.
- Latency: out_valid is visible the cycle after the slot-3 sample is presented. Outputs hold their value until the next completed frame.
- Violation A, early frame: in LOCKED, in_valid&frame with sel!=0.
  - sync_err pulses.
  - The partial frame is discarded; outputs are unchanged.
  - The sample is taken as slot 0 (shadow[0]) and sel=1. Stay LOCKED.
- Violation B, missing frame: in LOCKED, in_valid&!frame with sel=0.
  - sync_err pulses and the sample is dropped.
  - Go to HUNT with sel=0 and locked=0.
- frame with sel=3 is still Violation A; the frame is not completed.
- Simultaneous rst and in_valid: reset wins and the sample is lost.
- out_valid and sync_err never assert on the same cycle.

Optional Feature:
- TDM_DEMUX_ERRCNT_EN defined:
  - Adds output port err_cnt (8 bits).
  - err_cnt increments on every sync_err pulse and saturates at 255.
  - rst clears err_cnt to 0.
- Not defined: no err_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then clean frame: WIDTH=1, samples 1,0,1,1 with frame on the first → after the 4th edge out1..4=1,0,1,1, out_valid=1 for 1 cycle, sel=0, locked=1.
- Gapped frame: WIDTH=4, samples A,5,3,C with 2 idle cycles between each → out1..4=A,5,3,C and a single out_valid pulse. Outputs are unchanged during the gaps.
- HUNT filtering: 3 valid samples without frame, then a normal frame 2,4,6,8 → no sync_err or out_valid before the frame, then out1..4=2,4,6,8.
- Early frame: WIDTH=4, frame 1,2, then frame asserted with 7, then 8,9,A → sync_err pulses at 7, the earlier outputs are kept, and the result is out1..4=7,8,9,A.
- Missing frame: a full frame, then a valid sample with frame=0 at sel=0 → sync_err pulse, locked=0, sel=0. A later framed sequence relocks. With TDM_DEMUX_ERRCNT_EN, err_cnt=1; after 300 violations err_cnt=255.
- Mid-frame reset: 2 samples, then rst for 1 cycle → all outputs 0 and locked=0. Two further samples without frame produce no out_valid.
